// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared types and helpers for the bit-serial add/subtract controller.
//   sa_state_t : controller state encoding (IDLE, BUSY, DONE)
//   cnt_width  : width of the bit counter for a given operand width
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } sa_state_t;

    // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are enough.
    // The guard keeps the counter at least one bit wide for degenerate widths.
    function automatic int cnt_width(input int width);
        if (width < 2) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_1.sv
// full_adder_1
// Single-bit full adder used as the bit-slice of the serial datapath.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   sum   : sum bit
//   cout  : carry out
module full_adder_1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain combinational full adder: sum is the parity of the three inputs,
    // carry is their majority.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial add/subtract unit. Operands are accepted on a valid/ready
// handshake, added LSB first through one full adder over WIDTH cycles, and
// the result is presented on a second valid/ready handshake.
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_valid, o_ready    : operand handshake
//   i_a, i_b, i_sub     : operands, 0 = A+B, 1 = A-B
//   o_valid, i_ready    : result handshake
//   o_sum               : WIDTH-bit result
//   o_carry             : carry out of the MSB (subtract: 1 = no borrow)
//   o_overflow          : two's-complement signed overflow
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sa_state_t state_q;
    sa_state_t state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             carry_out_q;
    logic             ovf_q;

    logic             load;
    logic             step;
    logic             fa_sum;
    logic             fa_cout;

    // The one and only arithmetic element: it sees the current LSBs of the
    // operand shift registers and the running carry.
    full_adder_1 u_bit_slice (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State register. Reset aborts any in-flight operation so no result is
    // ever presented for it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs. Operands are only looked at in IDLE,
    // so requests arriving while busy or holding a result are simply ignored.
    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath. Subtraction is A + ~B + 1: B is inverted at load time and the
    // +1 enters as the initial carry. Each compute cycle the sum bit enters
    // the result register from the top, so after WIDTH shifts the first
    // (LSB) sum bit has landed in bit 0. Carry-out and overflow get their own
    // registers so they stay put once the carry register is reloaded.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (load) begin
            a_q     <= i_a;
            b_q     <= i_sub ? ~i_b : i_b;
            carry_q <= i_sub;
            cnt_q   <= '0;
        end else if (step) begin
            res_q   <= {fa_sum, res_q[WIDTH-1:1]};
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= fa_cout;
            cnt_q   <= cnt_q + CW'(1);
            // On the MSB slice, carry_q is the carry into the MSB, so its XOR
            // with the adder's carry out is the signed overflow.
            if (cnt_q == LAST_BIT) begin
                carry_out_q <= fa_cout;
                ovf_q       <= carry_q ^ fa_cout;
            end
        end
    end

    assign o_sum      = res_q;
    assign o_carry    = carry_out_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
// Self-checking bench for serial_adder_ctrl at WIDTH=8. A behavioural model
// tracks when a result is due and what it must be (plain integer arithmetic),
// and a compare process checks the DUT against it on every falling edge.
// Directed tests pin the model with hand-computed literal results.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_sub;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_sum;
    logic         o_carry;
    logic         o_overflow;

    int errors = 0;
    int checks = 0;
    int cycle_count = 0;
    int accept_cycle = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   m_left = 0;
    bit   m_done = 1'b0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_sub      (i_sub),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_sum      (o_sum),
        .o_carry    (o_carry),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_count++;

    // Reference result from integer arithmetic: unsigned sum for the value
    // and carry, true signed result for the overflow.
    function automatic exp_t computeExpected(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sub);
        exp_t e;
        int   ua;
        int   ub;
        int   full;
        int   sa;
        int   sb;
        int   sres;
        ua = int'(a);
        ub = int'(b);
        if (sub) full = ua + ((~ub) & ((1 << W) - 1)) + 1;
        else     full = ua + ub;
        e.sum   = W'(full);
        e.carry = (full >= (1 << W));
        sa = a[W-1] ? ua - (1 << W) : ua;
        sb = b[W-1] ? ub - (1 << W) : ub;
        sres = sub ? sa - sb : sa + sb;
        e.ovf = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected,
                     $time);
        end
    endtask

    // Transaction-level model: an accepted op becomes due W edges later and
    // stays due until the consumer takes it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            exp_q.delete();
        end else if (m_done) begin
            if (i_ready) begin
                m_done = 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (i_valid) begin
            m_left = W;
            exp_q.push_back(computeExpected(i_a, i_b, i_sub));
        end
    end

    // Compare process: handshake outputs every cycle, result fields whenever
    // a result is due.
    always @(negedge clk) begin
        checkOutput("o_ready", 32'(o_ready), 32'(!m_done && m_left == 0));
        checkOutput("o_valid", 32'(o_valid), 32'(m_done));
        if (m_done) begin
            if (exp_q.size() == 0) begin
                checkOutput("model_queue", 32'(0), 32'(1));
            end else begin
                checkOutput("o_sum", 32'(o_sum), 32'(exp_q[0].sum));
                checkOutput("o_carry", 32'(o_carry), 32'(exp_q[0].carry));
                checkOutput("o_overflow", 32'(o_overflow), 32'(exp_q[0].ovf));
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int n = 0;
        @(posedge clk);
        #1;
        while (!o_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!o_ready) checkOutput("accept_timeout", 32'(o_ready), 32'(1));
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        i_sub   = sub;
        @(posedge clk);
        #1;
        accept_cycle = cycle_count;
        i_valid = 1'b0;
    endtask

    task automatic waitValid(output int at_cycle);
        int n = 0;
        @(negedge clk);
        while (!o_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_valid) checkOutput("valid_timeout", 32'(o_valid), 32'(1));
        at_cycle = cycle_count;
    endtask

    task automatic releaseResult();
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic runDirected(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sub, input logic [W-1:0] exp_sum,
                               input logic exp_carry, input logic exp_ovf);
        int vc;
        applyStimulus(a, b, sub);
        waitValid(vc);
        checkOutput({name, "_latency"}, 32'(vc - accept_cycle), 32'(W));
        checkOutput({name, "_sum"}, 32'(o_sum), 32'(exp_sum));
        checkOutput({name, "_carry"}, 32'(o_carry), 32'(exp_carry));
        checkOutput({name, "_ovf"}, 32'(o_overflow), 32'(exp_ovf));
        releaseResult();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vc;
        int hs;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_sub   = 1'b0;

        #3;
        checkOutput("reset_ready", 32'(o_ready), 32'(1));
        checkOutput("reset_valid", 32'(o_valid), 32'(0));
        checkOutput("reset_sum", 32'(o_sum), 32'(0));
        checkOutput("reset_carry", 32'(o_carry), 32'(0));
        checkOutput("reset_ovf", 32'(o_overflow), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        $display("[TB] directed add/sub vectors");
        runDirected("add_3c_05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
        runDirected("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        runDirected("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        runDirected("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        runDirected("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        $display("[TB] backpressure in DONE");
        applyStimulus(8'h12, 8'h34, 1'b0);
        waitValid(vc);
        i_valid = 1'b1;
        i_a     = 8'h11;
        i_b     = 8'h22;
        i_sub   = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_ready", 32'(o_ready), 32'(0));
            checkOutput("bp_valid", 32'(o_valid), 32'(1));
            checkOutput("bp_sum", 32'(o_sum), 32'(8'h46));
        end
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        hs = cycle_count;
        i_ready = 1'b0;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_a     = 8'hFF;
        waitValid(vc);
        checkOutput("bp_next_latency", 32'(vc - hs), 32'(W + 1));
        checkOutput("bp_next_sum", 32'(o_sum), 32'(8'h33));
        releaseResult();

        $display("[TB] reset mid-operation");
        applyStimulus(8'h3C, 8'h05, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ready", 32'(o_ready), 32'(1));
        checkOutput("abort_valid", 32'(o_valid), 32'(0));
        checkOutput("abort_sum", 32'(o_sum), 32'(0));
        checkOutput("abort_carry", 32'(o_carry), 32'(0));
        checkOutput("abort_ovf", 32'(o_overflow), 32'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("abort_no_valid", 32'(o_valid), 32'(0));
        runDirected("add_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        $display("[TB] random back-to-back operations");
        for (int k = 0; k < 100; k++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom));
            waitValid(vc);
            checkOutput("rand_latency", 32'(vc - accept_cycle), 32'(W));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            releaseResult();
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
